// File: rtl/mips_defs.sv
// Shared definitions for the fetch slice of the MIPS pipeline.
// Holds exception codes, the NOP encoding, the instruction-memory window,
// the fetch FSM state encoding and the packed slot carried toward decode.
package mips_defs;

  localparam logic [4:0]  EXC_INT    = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // ready to issue the next fetch
    WAIT  = 2'd1,  // request outstanding
    HOLD  = 2'd2,  // response buffered while decode is stalled
    DRAIN = 2'd3   // request killed by a redirect, swallow its ack
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
    logic [4:0]  exccode;
  } fetch_slot_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for a fetched instruction that decode could not
// take in the cycle it arrived.
// Ports:
//   clk       rising-edge clock
//   rst_ni    synchronous active-low reset
//   load_i    capture slot_i
//   unload_i  entry handed on; mark empty
//   clear_i   entry killed by a redirect; mark empty
//   slot_i    pc / code / exccode to capture
//   valid_o   entry present
//   slot_o    stored pc / code / exccode
module if_hold_buf
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  fetch_slot_t slot_i,
  output logic        valid_o,
  output fetch_slot_t slot_o
);

  logic        valid_q;
  fetch_slot_t slot_q;

  // NOTE: sequential state is written with non-blocking '<=' so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (clear_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: the payload is deliberately left without reset; valid_q qualifies
  // it, so resetting the wide data path would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load_i) begin
      slot_q <= slot_i;
    end
  end

  assign valid_o = valid_q;
  assign slot_o  = slot_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues F_pc to a variable-latency instruction
// memory, screens for AdEL, and hands pc/code/exccode to decode through the
// D registers, with a one-entry hold buffer for responses that arrive while
// decode is stalled. A redirect (flush) kills buffered and in-flight fetches.
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   F_pc                current fetch PC (stable while F_stall=1)
//   flush               redirect this cycle
//   D_stall             decode cannot accept a new instruction
//   imem_req/addr       memory request and word address
//   imem_ack/rdata      one-cycle response pulse with data
//   F_stall             pause for the PC register
//   D_valid/pc/code/exccode  decode-side instruction registers
module if_fetch #(
  parameter logic [31:0] IMEM_BASE  = mips_defs::IMEM_BASE,
  parameter int unsigned IMEM_WORDS = mips_defs::IMEM_WORDS,
  parameter logic [4:0]  EXC_ADEL   = mips_defs::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_pc,
  input  logic        flush,
  input  logic        D_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        F_stall,
  output logic        D_valid,
  output logic [31:0] D_pc,
  output logic [31:0] D_code,
  output logic [4:0]  D_exccode
);

  import mips_defs::*;

  fetch_state_e state_q, state_d;
  logic         d_valid_q, d_valid_d;
  fetch_slot_t  d_slot_q, d_slot_d;

  logic         deliver_mem, deliver_adel, deliver_buf, buf_load;
  logic         buf_valid;
  fetch_slot_t  buf_slot, mem_slot;

  // Range check in 33 bits so BASE + 4*WORDS cannot wrap past 2^32.
  logic [32:0] pc_ext, lo_ext, hi_ext;
  logic        addr_bad;

  assign pc_ext   = {1'b0, F_pc};
  assign lo_ext   = {1'b0, IMEM_BASE};
  assign hi_ext   = lo_ext + ({1'b0, 32'(IMEM_WORDS)} << 2);
  assign addr_bad = (F_pc[1:0] != 2'b00) || (pc_ext < lo_ext) || (pc_ext >= hi_ext);

  assign imem_addr = F_pc;
  assign mem_slot  = '{pc: F_pc, code: imem_rdata, exccode: 5'd0};

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush outranks both ack and D_stall.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!flush && !addr_bad) state_d = WAIT;
      WAIT: begin
        if (imem_ack)   state_d = (flush || !D_stall) ? IDLE : HOLD;
        else if (flush) state_d = DRAIN;
      end
      HOLD:    if (flush || !D_stall) state_d = IDLE;
      DRAIN:   if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control logic. F_stall is 0 during flush so the PC register
  // loads its redirect target.
  always_comb begin
    imem_req     = 1'b0;
    F_stall      = 1'b0;
    deliver_mem  = 1'b0;
    deliver_adel = 1'b0;
    deliver_buf  = 1'b0;
    buf_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (!addr_bad)    begin imem_req = 1'b1; F_stall = 1'b1; end
          else if (D_stall) F_stall = 1'b1;
          else              deliver_adel = 1'b1;
        end
      end
      WAIT: begin
        // Request stays up until the ack cycle and drops with the ack.
        imem_req = !imem_ack;
        if (!flush) begin
          if (!imem_ack)    F_stall = 1'b1;
          else if (D_stall) begin buf_load = 1'b1; F_stall = 1'b1; end
          else              deliver_mem = 1'b1;
        end
      end
      HOLD: begin
        if (!flush) begin
          F_stall     = D_stall;
          deliver_buf = !D_stall;
        end
      end
      DRAIN:   F_stall = !flush;
      default: ;
    endcase
    if (!reset) begin
      imem_req     = 1'b0;
      F_stall      = 1'b0;
      deliver_mem  = 1'b0;
      deliver_adel = 1'b0;
      deliver_buf  = 1'b0;
      buf_load     = 1'b0;
    end
  end

  if_hold_buf u_hold_buf (
    .clk      (clk),
    .rst_ni   (reset),
    .load_i   (buf_load),
    .unload_i (deliver_buf),
    .clear_i  (flush),
    .slot_i   (mem_slot),
    .valid_o  (buf_valid),
    .slot_o   (buf_slot)
  );

  // Decode-side registers. A cycle with neither delivery nor stall leaves a
  // bubble; D_pc is kept so it still names the last delivered instruction.
  always_comb begin
    d_valid_d = d_valid_q;
    d_slot_d  = d_slot_q;
    if (flush) begin
      d_valid_d        = 1'b0;
      d_slot_d.code    = NOP_WORD;
      d_slot_d.exccode = 5'd0;
    end else if (deliver_mem) begin
      d_valid_d = 1'b1;
      d_slot_d  = mem_slot;
    end else if (deliver_adel) begin
      d_valid_d = 1'b1;
      d_slot_d  = '{pc: F_pc, code: NOP_WORD, exccode: EXC_ADEL};
    end else if (deliver_buf && buf_valid) begin
      d_valid_d = 1'b1;
      d_slot_d  = buf_slot;
    end else if (!D_stall) begin
      d_valid_d        = 1'b0;
      d_slot_d.code    = NOP_WORD;
      d_slot_d.exccode = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_valid_q <= 1'b0;
      d_slot_q  <= '{pc: IMEM_BASE, code: NOP_WORD, exccode: 5'd0};
    end else begin
      d_valid_q <= d_valid_d;
      d_slot_q  <= d_slot_d;
    end
  end

  assign D_valid   = d_valid_q;
  assign D_pc      = d_slot_q.pc;
  assign D_code    = d_slot_q.code;
  assign D_exccode = d_slot_q.exccode;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage between the next-PC register and the decode stage.
- Takes the current fetch PC (`F_pc`) and issues a request to a variable-latency instruction memory.
- Delivers `D_pc`/`D_code` to decode through a one-entry hold buffer.
- Generates the pause signal back to the PC register, screens for AdEL fetch exceptions, and kills in-flight or buffered fetches on redirect.

Parameters:
- IMEM_BASE, 32'h0000_3000, lowest legal instruction address
- IMEM_WORDS, 4096, legal range is [IMEM_BASE, IMEM_BASE + 4*IMEM_WORDS)
- EXC_ADEL, 5'd4, exception code for an address error on fetch

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low: sampled at posedge clk; 0 = reset
- F_pc  in  32  current fetch PC from the next-PC register; stable while F_stall=1
- flush  in  1  redirect this cycle (EPC return, interrupt entry, taken branch/jump kill)
- D_stall  in  1  decode cannot accept a new instruction this cycle
- imem_req  out  1  request valid
- imem_addr  out  32  word address = F_pc
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word
- F_stall  out  1  drives the PC register's pause input; 1 = hold F_pc
- D_valid  out  1  D_pc/D_code hold a live instruction
- D_pc  out  32  PC of the delivered instruction
- D_code  out  32  instruction word; 0 (sll nop) when not valid
- D_exccode  out  5  0, or EXC_ADEL for a faulting fetch

Behaviour:
- **Reset** (reset==0 at posedge):
  - state=IDLE; D_valid=0, D_pc=IMEM_BASE, D_code=0, D_exccode=0.
  - Hold buffer empty; drop flag cleared.
  - imem_req=0 during the reset cycle.
  - Reset overrides flush, ack and D_stall. A reset in mid-WAIT abandons the request; the memory is reset together with this block.
- **States:** IDLE, WAIT (request outstanding), HOLD (response buffered, decode stalled), DRAIN (discard one stale ack).
- **addr_bad** = F_pc[1:0]!=0, OR F_pc<IMEM_BASE, OR F_pc>=IMEM_BASE+4*IMEM_WORDS. Compare in 33-bit arithmetic so the upper bound does not wrap.
- **IDLE:**
  - addr_bad=0: assert imem_req and go to WAIT.
  - addr_bad=1: issue no request. If D_stall=0, load D with D_pc=F_pc, D_code=0, D_exccode=EXC_ADEL, D_valid=1; F_stall=0. Otherwise F_stall=1 and remain in IDLE.
- **WAIT:**
  - imem_req stays high until the ack cycle, then drops combinationally with ack.
  - On ack with D_stall=0: D_pc=F_pc, D_code=imem_rdata, D_exccode=0, D_valid=1; F_stall=0 in that same cycle; next state IDLE.
  - On ack with D_stall=1: capture into the hold buffer; go to HOLD; F_stall=1.
  - No ack: F_stall=1.
- **HOLD:**
  - F_stall=D_stall.
  - When D_stall=0: buffer moves to D, then IDLE.
- **DRAIN:**
  - F_stall=1, imem_req=0.
  - On ack: discard the data and go to IDLE.
- **D_stall=1 with no delivery:** D registers hold their values.
- **flush=1** (priority over D_stall and over ack):
  - D_valid=0, D_code=0, D_exccode=0. D_pc is unchanged.
  - From WAIT without ack: go to DRAIN.
  - From WAIT with ack in the same cycle: drop the data, go to IDLE.
  - From HOLD: empty the buffer, go to IDLE.
  - From IDLE or DRAIN: next state is IDLE, or stay in DRAIN if no ack has arrived yet.
  - F_stall=0 during flush, so the PC register loads its redirect target.
- **Throughput and latency:**
  - One instruction per cycle is never guaranteed: minimum 2 cycles per fetch (IDLE→WAIT with ack in WAIT).
  - Latency is F_pc → D output at the posedge after ack.
- **Unexpected ack:** an ack while in IDLE or HOLD is ignored.

Decomposition:
- Shared package (mips_defs) holds:
  - exception codes: EXC_ADEL=4, EXC_INT=0
  - NOP word 32'h0
  - IMEM_BASE
  - state encoding typedef: IDLE=2'd0, WAIT=2'd1, HOLD=2'd2, DRAIN=2'd3
- Natural sub-module: if_hold_buf, a one-entry pc/code/exccode register with load, unload and clear.

Test Plan:
- Reset with F_pc=32'h3000, ack 3 cycles after the request, D_stall=0 → imem_addr=32'h3000; D_pc=32'h3000, D_code=rdata, D_valid=1 one posedge after ack; F_stall low only in the ack cycle.
- F_pc=32'h3002 → no imem_req; D_exccode=4, D_code=0, D_pc=32'h3002. Then F_pc=32'h2FFC and F_pc=32'h7000 (IMEM_WORDS=4096) → same AdEL result for each.
- Ack for 32'h3004 while D_stall=1 for 2 cycles → state HOLD, F_stall=1, D unchanged. The cycle D_stall falls: F_stall=0 and D_code=rdata on the next posedge.
- flush 1 cycle after the request, ack 2 cycles later carrying 32'hDEADBEEF → DRAIN; D_code never equals 32'hDEADBEEF; D_valid=0; next request uses the new F_pc=32'h4180.
- flush in the same cycle as ack → data dropped, state IDLE, D_valid=0, F_stall=0.
- reset driven 0 while in WAIT → next cycle IDLE, imem_req=0, D_valid=0, D_pc=32'h3000.
